// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback logic and the register file: read ports,
// two write ports, and the load-issue handshake with its scoreboard outputs.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                wa_en;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;

    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;

    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [AW:0]         pending_cnt;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               issue_valid, issue_rd,
        input  rd_data, rd_busy, issue_ready, pending_cnt
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               issue_valid, issue_rd,
        output rd_data, rd_busy, issue_ready, pending_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with hardwired-zero x0, optional write-to-read
// bypass and a per-register load scoreboard exposed as an issue handshake.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [AW:0]      pending_cnt_q;
    logic [AW:0]      pending_cnt_d;

    logic wa_hit;
    logic wb_hit;
    logic issue_ready;
    logic issue_fire;
    logic cnt_inc;
    logic cnt_dec;

    // Gating with reset keeps bypassed data off the read ports while reset is held.
    assign wa_hit = reset && bus.wa_en && (bus.wa_addr != '0);
    assign wb_hit = reset && bus.wb_en && (bus.wb_addr != '0);

    assign issue_ready = !pending_q[bus.issue_rd] ||
                         (bus.wb_en && (bus.wb_addr == bus.issue_rd));
    assign issue_fire  = reset && bus.issue_valid && issue_ready && (bus.issue_rd != '0);

    // A set and clear of the same register leaves it pending, so it is not a decrement.
    assign cnt_inc = issue_fire && !pending_q[bus.issue_rd];
    assign cnt_dec = wb_hit && pending_q[bus.wb_addr] &&
                     !(issue_fire && (bus.issue_rd == bus.wb_addr));

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wa_hit) begin
            regs_d[bus.wa_addr] = bus.wa_data;
        end
        if (wb_hit) begin
            regs_d[bus.wb_addr]    = bus.wb_data;
            pending_d[bus.wb_addr] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_cnt_d = pending_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q     <= '0;
            pending_cnt_q <= '0;
        end else begin
            regs_q        <= regs_d;
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.pending_cnt = pending_cnt_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            wb_match;

        assign addr     = bus.rd_addr[g*AW +: AW];
        assign wb_match = bus.wb_en && (bus.wb_addr == addr);

        // Port B is applied last so it overrides port A on a shared address.
        always_comb begin
            data = regs_q[addr];
            if (BYPASS && wa_hit && (bus.wa_addr == addr)) begin
                data = bus.wa_data;
            end
            if (BYPASS && wb_hit && (bus.wb_addr == addr)) begin
                data = bus.wb_data;
            end
            if (addr == '0) begin
                data = '0;
            end
        end

        assign bus.rd_data[g*XLEN +: XLEN] = data;
        assign bus.rd_busy[g]              = pending_q[addr] && !(BYPASS && wb_match);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: one BYPASS=1 and one BYPASS=0 instance (NREGS=16, NRD=4)
// share directed stimulus and are compared every cycle against a behavioural model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 4;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic              wa_en = 1'b0;
    logic [AW-1:0]     wa_addr = '0;
    logic [XLEN-1:0]   wa_data = '0;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              issue_valid = 1'b0;
    logic [AW-1:0]     issue_rd = '0;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_a ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_b ();

    assign if_a.rd_addr = rd_addr;     assign if_b.rd_addr = rd_addr;
    assign if_a.wa_en = wa_en;         assign if_b.wa_en = wa_en;
    assign if_a.wa_addr = wa_addr;     assign if_b.wa_addr = wa_addr;
    assign if_a.wa_data = wa_data;     assign if_b.wa_data = wa_data;
    assign if_a.wb_en = wb_en;         assign if_b.wb_en = wb_en;
    assign if_a.wb_addr = wb_addr;     assign if_b.wb_addr = wb_addr;
    assign if_a.wb_data = wb_data;     assign if_b.wb_data = wb_data;
    assign if_a.issue_valid = issue_valid; assign if_b.issue_valid = issue_valid;
    assign if_a.issue_rd = issue_rd;   assign if_b.issue_rd = issue_rd;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_data(input bit byp, input int port);
        logic [AW-1:0] a;
        a = rd_addr[port*AW +: AW];
        if (!reset || a == 0) return 32'h0;
        if (byp && wb_en && wb_addr == a) return wb_data;
        if (byp && wa_en && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input bit byp, input int port);
        logic [AW-1:0] a;
        a = rd_addr[port*AW +: AW];
        if (byp && wb_en && wb_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic exp_ready();
        return !m_pend[issue_rd] || (wb_en && wb_addr == issue_rd);
    endfunction

    function automatic logic [31:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_pend[i]);
        return 32'(n);
    endfunction

    task automatic checkOutput();
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("a_rd_data%0d", p), if_a.rd_data[p*XLEN +: XLEN], exp_data(1'b1, p));
            chk($sformatf("b_rd_data%0d", p), if_b.rd_data[p*XLEN +: XLEN], exp_data(1'b0, p));
            chk($sformatf("a_rd_busy%0d", p), 32'(if_a.rd_busy[p]), 32'(exp_busy(1'b1, p)));
            chk($sformatf("b_rd_busy%0d", p), 32'(if_b.rd_busy[p]), 32'(exp_busy(1'b0, p)));
        end
        chk("a_issue_ready", 32'(if_a.issue_ready), 32'(exp_ready()));
        chk("b_issue_ready", 32'(if_b.issue_ready), 32'(exp_ready()));
        chk("a_pending_cnt", 32'(if_a.pending_cnt), exp_cnt());
        chk("b_pending_cnt", 32'(if_b.pending_cnt), exp_cnt());
    endtask

    task automatic drive(input logic a_en, input logic [AW-1:0] a_addr, input logic [31:0] a_data,
                         input logic b_en, input logic [AW-1:0] b_addr, input logic [31:0] b_data,
                         input logic iv, input logic [AW-1:0] ird, input logic [15:0] ra);
        @(negedge clk);
        wa_en = a_en;  wa_addr = a_addr;  wa_data = a_data;
        wb_en = b_en;  wb_addr = b_addr;  wb_data = b_data;
        issue_valid = iv;  issue_rd = ird;  rd_addr = ra;
        #2;
    endtask

    task automatic commit();
        bit rdy;
        checkOutput();
        @(posedge clk);
        if (reset) begin
            rdy = exp_ready();
            if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (issue_valid && rdy && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic a_en, input logic [AW-1:0] a_addr, input logic [31:0] a_data,
                                 input logic b_en, input logic [AW-1:0] b_addr, input logic [31:0] b_data,
                                 input logic iv, input logic [AW-1:0] ird, input logic [15:0] ra);
        drive(a_en, a_addr, a_data, b_en, b_addr, b_data, iv, ird, ra);
        commit();
    endtask

    task automatic idle(input logic [15:0] ra, input logic [AW-1:0] ird);
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, ird, ra);
    endtask

    initial begin
        model_clear();
        idle(16'h0000, 4'd0);
        idle(16'h0000, 4'd0);
        reset = 1'b1;

        // Load to x2 outstanding, then async reset mid-cycle after writing x5.
        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 16'h0025);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 16'h0025);
        chk("lit_x5_before_reset", if_a.rd_data[0 +: 32], 32'hDEADBEEF);
        chk("lit_cnt_before_reset", 32'(if_a.pending_cnt), 32'd1);
        reset = 1'b0;
        model_clear();
        #1;
        chk("lit_x5_in_reset", if_a.rd_data[0 +: 32], 32'h0);
        chk("lit_cnt_in_reset", 32'(if_b.pending_cnt), 32'd0);
        chk("lit_ready_in_reset", 32'(if_a.issue_ready), 32'd1);
        commit();
        applyStimulus(1'b1, 4'd5, 32'h00001234, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 16'h0045);
        reset = 1'b1;

        // Load writeback to a register no longer pending after reset.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h00000077, 1'b0, 4'd0, 16'h0052);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd4, 16'h0452);
        chk("lit_x2_after_wb", if_b.rd_data[0 +: 32], 32'h00000077);
        chk("lit_x5_reset_write_ignored", if_b.rd_data[32 +: 32], 32'h0);
        chk("lit_cnt_no_underflow", 32'(if_a.pending_cnt), 32'd0);
        commit();

        // x0 is never written nor made pending.
        applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 16'h0000);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 16'h0000);
        chk("lit_x0_read", if_a.rd_data[96 +: 32], 32'h0);
        chk("lit_x0_busy", 32'(if_a.rd_busy), 32'd0);
        chk("lit_x0_cnt", 32'(if_a.pending_cnt), 32'd0);
        commit();

        // Dual write to x7: port B wins; BYPASS=0 still shows the old value.
        drive(1'b1, 4'd7, 32'h11111111, 1'b1, 4'd7, 32'h22222222, 1'b0, 4'd0, 16'h7777);
        chk("lit_x7_bypass", if_a.rd_data[0 +: 32], 32'h22222222);
        chk("lit_x7_nobypass_old", if_b.rd_data[0 +: 32], 32'h0);
        commit();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 16'h7777);
        chk("lit_x7_stored_b", if_b.rd_data[32 +: 32], 32'h22222222);
        commit();

        // Scoreboard set on x3, then cleared by its load writeback.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 16'h0030);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 16'h0030);
        chk("lit_x3_busy", 32'(if_a.rd_busy[1]), 32'd1);
        chk("lit_x3_not_ready", 32'(if_a.issue_ready), 32'd0);
        chk("lit_x3_cnt", 32'(if_a.pending_cnt), 32'd1);
        commit();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'h00000055, 1'b0, 4'd3, 16'h0030);
        chk("lit_x3_wb_busy_a", 32'(if_a.rd_busy[1]), 32'd0);
        chk("lit_x3_wb_data_a", if_a.rd_data[32 +: 32], 32'h00000055);
        chk("lit_x3_wb_busy_b", 32'(if_b.rd_busy[1]), 32'd1);
        chk("lit_x3_wb_ready", 32'(if_b.issue_ready), 32'd1);
        commit();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 16'h0030);
        chk("lit_x3_cnt_cleared", 32'(if_a.pending_cnt), 32'd0);
        commit();

        // Set and clear of x9 in the same cycle: set wins, count unchanged.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 16'h0009);
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h000000AB, 1'b1, 4'd9, 16'h0009);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd9, 16'h0009);
        chk("lit_x9_data", if_b.rd_data[0 +: 32], 32'h000000AB);
        chk("lit_x9_busy", 32'(if_a.rd_busy[0]), 32'd1);
        chk("lit_x9_cnt", 32'(if_a.pending_cnt), 32'd1);
        commit();

        // Fill x1..x15 and read four distinct registers at once.
        for (int i = 1; i < NREGS; i++) begin
            applyStimulus(1'b1, 4'(i), 32'(i * 16), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 16'hFC94);
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 16'hFC94);
        chk("lit_mp_p0", if_b.rd_data[0 +: 32], 32'h00000040);
        chk("lit_mp_p1", if_b.rd_data[32 +: 32], 32'h00000090);
        chk("lit_mp_p2", if_a.rd_data[64 +: 32], 32'h000000C0);
        chk("lit_mp_p3", if_a.rd_data[96 +: 32], 32'h000000F0);
        commit();

        // Issue loads to every non-zero register, then drain them.
        for (int i = 1; i < NREGS; i++) begin
            applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 16'h4321);
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 16'h4321);
        chk("lit_cnt_full", 32'(if_a.pending_cnt), 32'd15);
        chk("lit_full_not_ready", 32'(if_b.issue_ready), 32'd0);
        commit();
        for (int i = 1; i < NREGS; i++) begin
            applyStimulus(1'b1, 4'(i), 32'h0BAD0000, 1'b1, 4'(i), 32'(32'hA000 + i),
                          1'b0, 4'(i), {4'(i), 4'd1, 4'd2, 4'(i)});
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd15, 16'hF000);
        chk("lit_cnt_drained", 32'(if_b.pending_cnt), 32'd0);
        chk("lit_x15_drain_data", if_a.rd_data[96 +: 32], 32'h0000A00F);
        commit();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
